imem_loader: RTL and testbench

//  Writer side of the instruction memory. Receives a program as a byte stream

---
 rtl/loader_pkg.sv | 16 +
 rtl/imem_loader_word_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 109 ++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and default geometry.
package loader_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
    localparam int MAX_WORDS      = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into one word; word_full flags the byte that completes it.
// The last byte lands in the register on the same edge word_full is seen, so the word is stable the cycle after.
module word_assembler
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_full
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPW - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Shifting in from the top leaves the first byte in the lowest lane after a full word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (accept) begin
            word <= {byte_data, word[DATA_WIDTH-1:8]};
            cnt  <= (cnt == LAST) ? '0 : cnt + ONE;
        end
    end

    assign word_full = accept && (cnt == LAST);

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory words 0..N-1 and holds the CPU in reset until done.
// One write cycle per word (byte_ready low then), so a word costs at least 5 cycles.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wd,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0]   CAP    = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   ONE_W  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

    state_t              state;
    logic [ADDR_WIDTH:0] target;
    logic [ADDR_WIDTH:0] written;
    logic                idle_like;
    logic                count_ok;
    logic                start_ok;
    logic                accept;
    logic                word_full;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign count_ok  = (word_count != '0) && (word_count <= CAP);
    assign start_ok  = start && idle_like && count_ok;
    assign accept    = byte_valid && byte_ready;

    word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (imem_wd),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target     <= '0;
            written    <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        target     <= word_count;
                        written    <= '0;
                        imem_addr  <= '0;
                        error      <= 1'b0;
                        done       <= 1'b0;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                        state      <= LOAD;
                    end else if (start) begin
                        // Rejected start leaves DONE/IDLE outputs untouched apart from the flag.
                        error <= 1'b1;
                    end
                end
                LOAD: begin
                    if (word_full) begin
                        byte_ready <= 1'b0;
                        imem_we    <= 1'b1;
                        written    <= written + ONE_W;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    imem_we <= 1'b0;
                    if (written == target) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= DONE;
                    end else begin
                        imem_addr  <= imem_addr + ONE_A;
                        byte_ready <= 1'b1;
                        state      <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued by stimulus and checked by a monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_wr(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = 6'(addr);
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!reset && imem_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0d data 0x%h, expected no write", imem_addr, imem_wd);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(imem_addr), 64'(e.addr));
                chk("write_data", 64'(imem_wd), 64'(e.data));
                chk("ready_low_in_write", 64'(byte_ready), 64'd0);
            end
        end
    end

    task automatic do_start(input int wc);
        start = 1'b1;
        word_count = 7'(wc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: byte 0x%h not accepted within 100 cycles", b);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] d;

        // 1: reset state, then two back-to-back words
        @(negedge clk);
        @(negedge clk);
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_imem_we",    64'(imem_we),    64'd0);
        chk("rst_imem_addr",  64'(imem_addr),  64'd0);
        chk("rst_imem_wd",    64'(imem_wd),    64'd0);
        chk("rst_cpu_hold",   64'(cpu_hold),   64'd1);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_done",       64'(done),       64'd0);
        chk("rst_error",      64'(error),      64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cpu_hold", 64'(cpu_hold), 64'd1);

        do_start(2);
        chk("t1_busy", 64'(busy), 64'd1);
        push_wr(0, 32'h12345678);
        push_wr(1, 32'hDEADBEEF);
        send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        chk("t1_we_after_last", 64'(imem_we), 64'd1);
        chk("t1_not_done_yet",  64'(done),    64'd0);
        @(negedge clk);
        chk("t1_done",     64'(done),     64'd1);
        chk("t1_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("t1_busy_off", 64'(busy),     64'd0);

        // 2: rejected counts while in DONE, bytes held off
        do_start(0);
        chk("t2_err0",        64'(error),      64'd1);
        chk("t2_done_kept",   64'(done),       64'd1);
        chk("t2_hold_kept",   64'(cpu_hold),   64'd0);
        chk("t2_ready0",      64'(byte_ready), 64'd0);
        do_start(65);
        chk("t2_err65",       64'(error),      64'd1);
        chk("t2_busy65",      64'(busy),       64'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_ready_held", 64'(byte_ready), 64'd0);
        end
        byte_valid = 1'b0;

        // 3: word_count=1 with sparse byte_valid
        do_start(1);
        chk("t2_err_clear",  64'(error),      64'd0);
        chk("t3_done_clear", 64'(done),       64'd0);
        chk("t3_cpu_hold",   64'(cpu_hold),   64'd1);
        chk("t3_ready",      64'(byte_ready), 64'd1);
        push_wr(0, 32'h44332211);
        send_byte(8'h11, 2); send_byte(8'h22, 2); send_byte(8'h33, 2); send_byte(8'h44, 2);
        wait_done();
        chk("t3_all_written", 64'(exp_q.size()), 64'd0);

        // 4: full capacity load
        do_start(64);
        for (int i = 0; i < 64; i++) begin
            d = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            push_wr(i, d);
        end
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 4; k++)
                send_byte(8'(4*i+k), 0);
        wait_done();
        chk("t4_final_addr",  64'(imem_addr),    64'd63);
        chk("t4_all_written", 64'(exp_q.size()), 64'd0);

        // 5: reset mid-load discards the partial word
        do_start(3);
        push_wr(0, 32'hA3A2A1A0);
        for (int k = 0; k < 6; k++)
            send_byte(8'(8'hA0 + k), 0);
        reset = 1'b1;
        #1;
        chk("t5_cpu_hold", 64'(cpu_hold),   64'd1);
        chk("t5_busy",     64'(busy),       64'd0);
        chk("t5_ready",    64'(byte_ready), 64'd0);
        chk("t5_addr",     64'(imem_addr),  64'd0);
        chk("t5_wd",       64'(imem_wd),    64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_q_after_rst", 64'(exp_q.size()), 64'd0);
        do_start(1);
        push_wr(0, 32'h0D0C0B0A);
        send_byte(8'h0A, 0); send_byte(8'h0B, 0); send_byte(8'h0C, 0); send_byte(8'h0D, 0);
        wait_done();
        chk("t5_all_written", 64'(exp_q.size()), 64'd0);

        // 6: start during LOAD is ignored
        do_start(5);
        for (int i = 0; i < 5; i++) begin
            d = {8'(16*i+3), 8'(16*i+2), 8'(16*i+1), 8'(16*i)};
            push_wr(i, d);
        end
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 4; k++) begin
                if (i == 0 && k == 2) begin
                    do_start(2);
                    chk("t6_no_error", 64'(error), 64'd0);
                    chk("t6_busy",     64'(busy),  64'd1);
                end
                send_byte(8'(16*i+k), 0);
            end
        wait_done();
        chk("t6_final_addr",  64'(imem_addr),    64'd4);
        chk("t6_all_written", 64'(exp_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
